wb_ext_arbiter: RTL and testbench

WB_EXT_ARBITER -- requirements
Module: wb_ext_arbiter

---
 rtl/wb_ext_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_ext_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ext_arbiter.sv
// Wishbone arbiter: NUM_PORTS tile masters share one external bus.
// Round-robin grant after cyc release, stall timeout aborts with err.
module wb_ext_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_PORTS-1:0]            m_cyc_i,
  input  logic [NUM_PORTS-1:0]            m_stb_i,
  input  logic [NUM_PORTS-1:0]            m_we_i,
  input  logic [NUM_PORTS-1:0]            m_cab_i,
  input  logic [NUM_PORTS*3-1:0]          m_cti_i,
  input  logic [NUM_PORTS*2-1:0]          m_bte_i,
  output logic [NUM_PORTS-1:0]            m_ack_o,
  output logic [NUM_PORTS-1:0]            m_rty_o,
  output logic [NUM_PORTS-1:0]            m_err_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] m_dat_o,
  output logic [ADDR_WIDTH-1:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic [SEL_WIDTH-1:0]            s_sel_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic                            s_cab_o,
  output logic [2:0]                      s_cti_o,
  output logic [1:0]                      s_bte_o,
  input  logic                            s_ack_i,
  input  logic                            s_rty_i,
  input  logic                            s_err_i,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  output logic [NUM_PORTS-1:0]            grant_o,
  output logic                            timeout_o
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_t;

  state_t        state;
  logic [IW-1:0] g;
  logic [IW-1:0] lp;
  logic [IW-1:0] nxt;
  logic          any;
  logic [CW-1:0] cnt;
  logic          stall;
  logic          hit;
  int            k;

  // rotate search so the port after the last owner is looked at first
  always_comb begin
    nxt = lp;
    any = 1'b0;
    k   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      k = int'(lp) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!any && m_cyc_i[k]) begin
        any = 1'b1;
        nxt = IW'(k);
      end
    end
  end

  assign stall = (state == GRANT) && m_stb_i[g] &&
                 !(s_ack_i || s_rty_i || s_err_i);
  assign hit   = (TIMEOUT > 0) && stall && (cnt == TLAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      g     <= '0;
      lp    <= IW'(NUM_PORTS - 1);
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (any) begin
            g     <= nxt;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!m_cyc_i[g]) begin
            lp    <= g;
            state <= IDLE;
            cnt   <= '0;
          end else if (hit) begin
            state <= ABORT;
            cnt   <= '0;
          end else if (stall && TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ABORT: begin
          cnt <= '0;
          if (m_cyc_i[g]) begin
            state <= GRANT;
          end else begin
            lp    <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_cab_o   = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m_ack_o   = '0;
    m_rty_o   = '0;
    m_err_o   = '0;
    m_dat_o   = '0;
    grant_o   = '0;
    timeout_o = 1'b0;
    case (state)
      GRANT: begin
        s_adr_o    = m_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o    = m_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o    = m_sel_i[g*SEL_WIDTH +: SEL_WIDTH];
        s_cyc_o    = m_cyc_i[g];
        s_stb_o    = m_stb_i[g];
        s_we_o     = m_we_i[g];
        s_cab_o    = m_cab_i[g];
        s_cti_o    = m_cti_i[g*3 +: 3];
        s_bte_o    = m_bte_i[g*2 +: 2];
        m_ack_o[g] = s_ack_i;
        m_rty_o[g] = s_rty_i;
        m_err_o[g] = s_err_i;
        m_dat_o[g*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
        grant_o[g] = 1'b1;
      end
      ABORT: begin
        m_err_o[g] = 1'b1;
        grant_o[g] = 1'b1;
        timeout_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_ext_arbiter.sv
// Directed bench for wb_ext_arbiter: grant order, pass-through,
// timeout abort, async reset, timeout disabled.
module tb_wb_ext_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*AW-1:0] m_adr;
  logic [NP*DW-1:0] m_dat;
  logic [NP*SW-1:0] m_sel;
  logic [NP-1:0]  m_cyc, m_stb, m_we, m_cab;
  logic [NP*3-1:0] m_cti;
  logic [NP*2-1:0] m_bte;
  logic           s_ack, s_rty, s_err;
  logic [DW-1:0]  s_dat;

  logic [NP-1:0]  m_ack, m_rty, m_err, grant;
  logic [NP*DW-1:0] m_dato;
  logic [AW-1:0]  s_adr;
  logic [DW-1:0]  s_dato;
  logic [SW-1:0]  s_sel;
  logic           s_cyc, s_stb, s_we, s_cab, tout;
  logic [2:0]     s_cti;
  logic [1:0]     s_bte;

  logic [NP-1:0]  m_ack2, m_rty2, m_err2, grant2;
  logic [NP*DW-1:0] m_dato2;
  logic [AW-1:0]  s_adr2;
  logic [DW-1:0]  s_dato2;
  logic [SW-1:0]  s_sel2;
  logic           s_cyc2, s_stb2, s_we2, s_cab2, tout2;
  logic [2:0]     s_cti2;
  logic [1:0]     s_bte2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  wb_ext_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_cab_i(m_cab), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack), .m_rty_o(m_rty), .m_err_o(m_err),
    .m_dat_o(m_dato),
    .s_adr_o(s_adr), .s_dat_o(s_dato), .s_sel_o(s_sel),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_cab_o(s_cab), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_ack_i(s_ack), .s_rty_i(s_rty), .s_err_i(s_err),
    .s_dat_i(s_dat), .grant_o(grant), .timeout_o(tout)
  );

  wb_ext_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)
  ) dut_nt (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_cab_i(m_cab), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_ack_o(m_ack2), .m_rty_o(m_rty2), .m_err_o(m_err2),
    .m_dat_o(m_dato2),
    .s_adr_o(s_adr2), .s_dat_o(s_dato2), .s_sel_o(s_sel2),
    .s_cyc_o(s_cyc2), .s_stb_o(s_stb2), .s_we_o(s_we2),
    .s_cab_o(s_cab2), .s_cti_o(s_cti2), .s_bte_o(s_bte2),
    .s_ack_i(s_ack), .s_rty_i(s_rty), .s_err_i(s_err),
    .s_dat_i(s_dat), .grant_o(grant2), .timeout_o(tout2)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g;
  logic       seen2;
  int         ntout;

  initial begin
    rst   = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cab = '0;
    m_sel = '1; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_rty = 1'b0; s_err = 1'b0; s_dat = '0;
    for (int p = 0; p < NP; p++) begin
      m_adr[p*AW +: AW] = 32'h1000 + p;
      m_dat[p*DW +: DW] = 32'hA000 + p;
    end
    #3;
    chk("rst_grant", 128'(grant), 128'h0);
    chk("rst_scyc", 128'(s_cyc), 128'h0);
    chk("rst_tout", 128'(tout), 128'h0);
    tick();
    rst = 1'b1;

    m_cyc = 4'b0101;
    tick();
    chk("arb_g0", 128'(grant), 128'h1);
    chk("arb_adr0", 128'(s_adr), 128'h1000);
    chk("arb_cyc0", 128'(s_cyc), 128'h1);
    m_cyc[0] = 1'b0;
    #1;
    chk("arb_drop", 128'(s_cyc), 128'h0);
    tick();
    chk("arb_idle", 128'(grant), 128'h0);
    tick();
    chk("arb_g2", 128'(grant), 128'h4);
    chk("arb_adr2", 128'(s_adr), 128'h1002);
    m_cyc = '0;
    tick();

    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_cyc = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      tick();
      chk("rr_grant", 128'(grant), 128'(exp_g));
      m_cyc = m_cyc & ~exp_g;
      tick();
      chk("rr_idle", 128'(grant), 128'h0);
      m_cyc = m_cyc | exp_g;
    end
    m_cyc = '0;
    tick();

    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick();
    chk("ack_grant", 128'(grant), 128'h2);
    chk("ack_stb", 128'(s_stb), 128'h1);
    s_ack = 1'b1;
    s_dat = 32'hDEADBEEF;
    #1;
    chk("ack_vec", 128'(m_ack), 128'h2);
    chk("ack_dat", 128'(m_dato), 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000);
    chk("ack_err", 128'(m_err), 128'h0);
    m_cyc[1] = 1'b0;
    #1;
    chk("ack_rel", 128'(m_ack), 128'h2);
    tick();
    chk("ack_idle", 128'(grant), 128'h0);
    s_ack = 1'b0;
    s_dat = '0;
    m_stb = '0;

    m_cyc[3] = 1'b1;
    m_stb[3] = 1'b1;
    tick();
    chk("to_grant", 128'(grant), 128'h8);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("to_wait", 128'({s_cyc, tout, m_err}), 128'h20);
    end
    tick();
    chk("to_err", 128'(m_err), 128'h8);
    chk("to_pulse", 128'(tout), 128'h1);
    chk("to_cyc", 128'({s_cyc, s_stb}), 128'h0);
    s_ack = 1'b1;
    #1;
    chk("to_ignack", 128'(m_ack), 128'h0);
    s_ack = 1'b0;
    tick();
    chk("to_regrant", 128'(grant), 128'h8);
    chk("to_clear", 128'({tout, m_err}), 128'h0);
    m_cyc = '0;
    m_stb = '0;
    tick();
    chk("to_idle", 128'(grant), 128'h0);

    m_cyc[2] = 1'b1;
    m_stb[2] = 1'b1;
    tick();
    chk("mr_grant", 128'(grant), 128'h4);
    chk("mr_stb", 128'(s_stb), 128'h1);
    m_cyc[1] = 1'b1;
    #2;
    chk("mr_pend", 128'(m_ack), 128'h0);
    rst = 1'b0;
    #1;
    chk("mr_bus", 128'({s_cyc, s_stb, s_adr}), 128'h0);
    chk("mr_grant0", 128'(grant), 128'h0);
    rst = 1'b1;
    tick();
    chk("mr_first", 128'(grant), 128'h2);
    m_cyc = '0;
    m_stb = '0;
    tick();

    rst = 1'b0;
    #1;
    rst = 1'b1;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    seen2 = 1'b0;
    ntout = 0;
    tick();
    for (int n = 0; n < 1000; n++) begin
      if (m_err2 != '0 || tout2) seen2 = 1'b1;
      if (tout) ntout++;
      tick();
    end
    chk("nt_noerr", 128'(seen2), 128'h0);
    chk("nt_grant", 128'(grant2), 128'h1);
    chk("nt_ref_to", 128'(ntout > 0), 128'h1);
    m_cyc = '0;
    m_stb = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
